// File: rtl/sha_pkg.sv
// Shared widths and sweep state encoding for the nonce sweep controller.
package sha_pkg;
  localparam int BLOCK_W = 512;
  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    REPORT = 3'd4,
    DRAIN  = 3'd5
  } sweep_state_t;
endpackage

// File: rtl/hash_lt_cmp.sv
// Unsigned 256-bit magnitude compare (a < b), kept separate so it can be
// pipelined later without touching the sequencer.
module hash_lt_cmp
  import sha_pkg::*;
(
  input  logic [HASH_W-1:0] a,
  input  logic [HASH_W-1:0] b,
  output logic              lt
);
  // Plain unsigned compare.
  assign lt = (a < b);
endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep sequencer for one sha256_module instance.
// Inserts each candidate nonce into the template, starts the core, compares
// the digest with the target and stops on the first hit or end of range.
// Optional build macro: NONCE_SWEEP_STATS_EN adds the hash_count port.
module nonce_sweep_ctrl
  import sha_pkg::*;
#(
  parameter int NONCE_LSB = 96,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  input  logic [BLOCK_W-1:0] tmpl_block,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  input  logic [HASH_W-1:0]  target,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_block,
  input  logic [HASH_W-1:0]  core_hash,
  input  logic               core_done,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [NONCE_W-1:0] result_nonce,
  output logic [HASH_W-1:0]  result_hash,
  input  logic               result_ack
`ifdef NONCE_SWEEP_STATS_EN
  ,
  output logic [CNT_W-1:0]   hash_count
`endif
);

  sweep_state_t       state, state_d;
  logic [BLOCK_W-1:0] tmpl_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] last_q;
  logic [HASH_W-1:0]  target_q;
  logic [HASH_W-1:0]  hash_q;
  logic               hit;
  logic               accept_start;
  logic               at_last;

  function automatic logic [BLOCK_W-1:0] insert_nonce(
    input logic [BLOCK_W-1:0] tmpl,
    input logic [NONCE_W-1:0] n
  );
    logic [BLOCK_W-1:0] r;
    r = tmpl;
    r[NONCE_LSB +: NONCE_W] = n;
    return r;
  endfunction

  hash_lt_cmp u_cmp (
    .a  (hash_q),
    .b  (target_q),
    .lt (hit)
  );

  assign accept_start = (state == IDLE) && cmd_start && !cmd_abort;
  assign at_last      = (nonce_q == last_q);
  assign core_start   = (state == ISSUE);
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; abort always wins over progress.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (accept_start) state_d = (nonce_first > nonce_last) ? REPORT : ISSUE;
      ISSUE:  state_d = cmd_abort ? DRAIN : WAIT;
      WAIT: begin
        // An abort coinciding with done has nothing left to drain.
        if (cmd_abort)      state_d = core_done ? IDLE : DRAIN;
        else if (core_done) state_d = CHECK;
      end
      CHECK: begin
        if (cmd_abort)       state_d = IDLE;
        else if (hit)        state_d = REPORT;
        else if (at_last)    state_d = REPORT;
        else                 state_d = ISSUE;
      end
      REPORT: if (cmd_abort || result_ack) state_d = IDLE;
      DRAIN:  if (core_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Config latch, nonce stepping, digest capture and result reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmpl_q       <= '0;
      nonce_q      <= '0;
      last_q       <= '0;
      target_q     <= '0;
      hash_q       <= '0;
      core_block   <= '0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      result_nonce <= '0;
      result_hash  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_start) begin
            tmpl_q   <= tmpl_block;
            nonce_q  <= nonce_first;
            last_q   <= nonce_last;
            target_q <= target;
            if (nonce_first > nonce_last) begin
              exhausted    <= 1'b1;
              result_nonce <= nonce_last;
              result_hash  <= '0;
            end else begin
              core_block <= insert_nonce(tmpl_block, nonce_first);
            end
          end
        end
        WAIT: begin
          if (core_done && !cmd_abort) hash_q <= core_hash;
        end
        CHECK: begin
          if (!cmd_abort) begin
            if (hit) begin
              found        <= 1'b1;
              result_nonce <= nonce_q;
              result_hash  <= hash_q;
            end else if (at_last) begin
              exhausted    <= 1'b1;
              result_nonce <= nonce_q;
              result_hash  <= hash_q;
            end else begin
              nonce_q    <= nonce_q + 32'd1;
              core_block <= insert_nonce(tmpl_q, nonce_q + 32'd1);
            end
          end
        end
        REPORT: begin
          if (cmd_abort || result_ack) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NONCE_SWEEP_STATS_EN
  // Saturating count of digests accepted during a sweep.
  always_ff @(posedge clk) begin
    if (reset || accept_start) begin
      hash_count <= '0;
    end else if (state == WAIT && core_done && !cmd_abort) begin
      if (hash_count != {CNT_W{1'b1}}) hash_count <= hash_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed bench for nonce_sweep_ctrl with a fixed-latency stub SHA core.
module tb_nonce_sweep_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_start, cmd_abort;
  logic [511:0] tmpl_block;
  logic [31:0]  nonce_first, nonce_last;
  logic [255:0] target;
  logic         core_start;
  logic [511:0] core_block;
  logic [255:0] core_hash;
  logic         core_done;
  logic         busy, found, exhausted;
  logic [31:0]  result_nonce;
  logic [255:0] result_hash;
  logic         result_ack;
`ifdef NONCE_SWEEP_STATS_EN
  logic [31:0]  hash_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] hit_nonce = 32'hDEAD_BEEF;
  int          starts;
  logic        running;
  logic [2:0]  lat;
  logic [31:0] cur_n;
  logic [511:0] cur_blk;
  int          blk_err;

  always #5 clk = ~clk;

  nonce_sweep_ctrl dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .tmpl_block(tmpl_block), .nonce_first(nonce_first), .nonce_last(nonce_last),
    .target(target), .core_start(core_start), .core_block(core_block),
    .core_hash(core_hash), .core_done(core_done), .busy(busy), .found(found),
    .exhausted(exhausted), .result_nonce(result_nonce), .result_hash(result_hash),
    .result_ack(result_ack)
`ifdef NONCE_SWEEP_STATS_EN
    , .hash_count(hash_count)
`endif
  );

  function automatic logic [255:0] stub_hash(input logic [31:0] n);
    if (n == hit_nonce) return 256'h10;
    return {8'hF0, 216'd0, n};
  endfunction

  // Stub core: done 4 cycles after start, digest derived from the nonce field.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (reset) begin
      running   <= 1'b0;
      lat       <= 3'd0;
      core_hash <= '0;
      starts    <= 0;
      blk_err   <= 0;
      cur_n     <= '0;
      cur_blk   <= '0;
    end else if (core_start) begin
      running <= 1'b1;
      lat     <= 3'd3;
      cur_n   <= core_block[96 +: 32];
      cur_blk <= core_block;
      starts  <= starts + 1;
      if ((core_block & ~({480'd0, 32'hFFFF_FFFF} << 96)) !==
          (tmpl_block & ~({480'd0, 32'hFFFF_FFFF} << 96)))
        blk_err <= blk_err + 1;
    end else if (running) begin
      if (core_block !== cur_blk) blk_err <= blk_err + 1;
      if (lat == 3'd1) begin
        core_done <= 1'b1;
        core_hash <= stub_hash(cur_n);
        running   <= 1'b0;
      end
      lat <= lat - 3'd1;
    end
  end

  task automatic start_cmd(input logic [31:0] f, input logic [31:0] l, input logic [255:0] t);
    nonce_first = f;
    nonce_last  = l;
    target      = t;
    cmd_start   = 1'b1;
    @(negedge clk);
    cmd_start   = 1'b0;
  endtask

  task automatic wait_report(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (found || exhausted) got = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s: no report within 400 cycles (busy=%0b)", name, busy);
    end
  endtask

  task automatic ack_and_check(input string name);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    n_vec++;
    if ({busy, found, exhausted} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_ack: busy/found/exh=%b expected 000", name, {busy, found, exhausted});
    end
  endtask

  task automatic check_result(input string name, input logic f, input logic e,
                              input logic [31:0] n, input logic [255:0] h, input int s);
    n_vec++;
    if (found !== f || exhausted !== e) begin
      n_err++;
      $display("FAIL %s_flags: found=%b exh=%b expected %b %b", name, found, exhausted, f, e);
    end
    n_vec++;
    if (result_nonce !== n) begin
      n_err++;
      $display("FAIL %s_nonce: got %h expected %h", name, result_nonce, n);
    end
    n_vec++;
    if (result_hash !== h) begin
      n_err++;
      $display("FAIL %s_hash: got %h expected %h", name, result_hash, h);
    end
    n_vec++;
    if (s !== starts) begin
      n_err++;
      $display("FAIL %s_starts: got %0d expected %0d", name, starts, s);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, found, exhausted, core_start} !== 4'b0 || core_block !== '0 ||
        result_nonce !== '0 || result_hash !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b found=%b exh=%b start=%b blk=%h rn=%h",
               busy, found, exhausted, core_start, core_block[127:96], result_nonce);
    end
`ifdef NONCE_SWEEP_STATS_EN
    n_vec++;
    if (hash_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d expected 0", hash_count);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_hit;
    int s0;
    hit_nonce = 32'hDEAD_BEEF;
    s0 = starts;
    start_cmd(32'd5, 32'd9, {256{1'b1}});
    wait_report("first_hit");
    check_result("first_hit", 1'b1, 1'b0, 32'd5, stub_hash(32'd5), s0 + 1);
    ack_and_check("first_hit");
  endtask

  task automatic test_exhaust;
    int s0;
    s0 = starts;
    start_cmd(32'd0, 32'd3, 256'd0);
    wait_report("exhaust");
    check_result("exhaust", 1'b0, 1'b1, 32'd3, stub_hash(32'd3), s0 + 4);
`ifdef NONCE_SWEEP_STATS_EN
    n_vec++;
    if (hash_count !== 32'd4) begin
      n_err++;
      $display("FAIL exhaust_count: got %0d expected 4", hash_count);
    end
`endif
    ack_and_check("exhaust");
  endtask

  task automatic test_mid_hit;
    int s0;
    hit_nonce = 32'h102;
    s0 = starts;
    start_cmd(32'h100, 32'h1FF, 256'h100);
    // A second start mid-sweep must be ignored.
    repeat (3) @(negedge clk);
    start_cmd(32'h0, 32'h0, {256{1'b1}});
    wait_report("mid_hit");
    check_result("mid_hit", 1'b1, 1'b0, 32'h102, 256'h10, s0 + 3);
    ack_and_check("mid_hit");
    hit_nonce = 32'hDEAD_BEEF;
  endtask

  task automatic test_no_wrap;
    int s0;
    s0 = starts;
    start_cmd(32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'd0);
    wait_report("no_wrap");
    check_result("no_wrap", 1'b0, 1'b1, 32'hFFFF_FFFF, stub_hash(32'hFFFF_FFFF), s0 + 2);
    ack_and_check("no_wrap");
  endtask

  task automatic test_abort_wait;
    int s0;
    bit idle;
    s0 = starts;
    start_cmd(32'd0, 32'd100, 256'd0);
    @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || running !== 1'b1) begin
      n_err++;
      $display("FAIL abort_drain_busy: busy=%b core_running=%b expected 1 1", busy, running);
    end
    idle = 1'b0;
    for (int i = 0; i < 50 && !idle; i++) begin
      if (!busy) idle = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!idle || running !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0 || starts !== s0 + 1) begin
      n_err++;
      $display("FAIL abort_idle: idle=%b running=%b found=%b exh=%b starts=%0d expected 1 0 0 0 %0d",
               idle, running, found, exhausted, starts, s0 + 1);
    end
    s0 = starts;
    start_cmd(32'd5, 32'd9, {256{1'b1}});
    wait_report("abort_rerun");
    check_result("abort_rerun", 1'b1, 1'b0, 32'd5, stub_hash(32'd5), s0 + 1);
    ack_and_check("abort_rerun");
  endtask

  task automatic test_empty_range;
    int s0;
    s0 = starts;
    start_cmd(32'd10, 32'd2, {256{1'b1}});
    n_vec++;
    if (exhausted !== 1'b1 || found !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL empty_one_cycle: exh=%b found=%b busy=%b expected 1 0 1", exhausted, found, busy);
    end
    check_result("empty", 1'b0, 1'b1, 32'd2, 256'd0, s0);
`ifdef NONCE_SWEEP_STATS_EN
    n_vec++;
    if (hash_count !== 32'd0) begin
      n_err++;
      $display("FAIL empty_count: got %0d expected 0", hash_count);
    end
`endif
    ack_and_check("empty");
  endtask

  task automatic test_reset_mid;
    start_cmd(32'd0, 32'd50, 256'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || core_block !== '0 || core_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b start=%b blk_nonce=%h expected 0 0 0",
               busy, core_start, core_block[127:96]);
    end
    @(negedge clk);
  endtask

  task automatic test_block_integrity;
    n_vec++;
    if (blk_err !== 0) begin
      n_err++;
      $display("FAIL block_integrity: %0d template/stability violations expected 0", blk_err);
    end
  endtask

  initial begin
    reset       = 1'b1;
    cmd_start   = 1'b0;
    cmd_abort   = 1'b0;
    result_ack  = 1'b0;
    tmpl_block  = {16{32'hA5C3_0F1E}};
    nonce_first = '0;
    nonce_last  = '0;
    target      = '0;
    @(negedge clk);
    test_reset;
    test_first_hit;
    test_exhaust;
    test_mid_hit;
    test_no_wrap;
    test_abort_wait;
    test_empty_range;
    test_block_integrity;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
